// File: rtl/usb_tx_buf_src_if.sv
// usb_tx_buf_src_if: command, TX-buffer RAM and packet-generator signals
// for usb_tx_buf_src. The master modport is the buffer source itself; the
// slave modport is the surrounding endpoint logic, RAM and usb_tx_pkt.
interface usb_tx_buf_src_if #(
  parameter int ADDR_W = 11
);
  // command channel from endpoint logic
  logic              cmd_valid;
  logic              cmd_ready;
  logic [3:0]        cmd_pid;
  logic [ADDR_W-1:0] cmd_addr;
  logic [9:0]        cmd_len;
  // synchronous-read TX buffer RAM
  logic [ADDR_W-1:0] buf_addr;
  logic              buf_re;
  logic [7:0]        buf_rdata;
  // packet generator side
  logic              pkt_start;
  logic              pkt_done;
  logic [3:0]        pkt_pid;
  logic [9:0]        pkt_len;
  logic [7:0]        pkt_data;
  logic              pkt_data_ack;

  modport master (
    input  cmd_valid, cmd_pid, cmd_addr, cmd_len, buf_rdata, pkt_done, pkt_data_ack,
    output cmd_ready, buf_addr, buf_re, pkt_start, pkt_pid, pkt_len, pkt_data
  );

  modport slave (
    output cmd_valid, cmd_pid, cmd_addr, cmd_len, buf_rdata, pkt_done, pkt_data_ack,
    input  cmd_ready, buf_addr, buf_re, pkt_start, pkt_pid, pkt_len, pkt_data
  );
endinterface

// File: rtl/usb_tx_buf_src.sv
// usb_tx_buf_src: takes one transmit command, prefetches the first payload
// byte from the TX buffer RAM, starts usb_tx_pkt and refills pkt_data on
// every consumer ack until the packet generator reports pkt_done.
// Optional protocol checker (sticky err output) enabled by defining
// USB_TX_BUF_SRC_CHECK_EN.
module usb_tx_buf_src #(
  parameter int ADDR_W = 11
) (
  input  logic             clk_48m,
  input  logic             rst,
  usb_tx_buf_src_if.master bus,
  output logic             busy,
  output logic             done
`ifdef USB_TX_BUF_SRC_CHECK_EN
  ,
  output logic             err
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREFETCH,
    S_PRE_CAP,
    S_START,
    S_XFER,
    S_WAIT_DONE
  } state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] ptr_reg, ptr_next;
  logic [9:0]        rem_reg, rem_next;
  logic [3:0]        pid_reg, pid_next;
  logic [9:0]        len_reg, len_next;
  logic [7:0]        data_reg;
  logic              refill_reg, refill_next;
  logic              done_reg, done_next;
  logic              rdy_en_reg;
  logic              rd_en;
  logic              capture;

  // The RAM returns data one cycle after a read; capture it either in the
  // second prefetch cycle or in the cycle after an ack-triggered refill.
  assign capture = (state_reg == S_PRE_CAP) || refill_reg;

  // State and datapath registers
  always_ff @(posedge clk_48m) begin
    if (rst) begin
      state_reg  <= S_IDLE;
      ptr_reg    <= '0;
      rem_reg    <= '0;
      pid_reg    <= '0;
      len_reg    <= '0;
      data_reg   <= '0;
      refill_reg <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      ptr_reg    <= ptr_next;
      rem_reg    <= rem_next;
      pid_reg    <= pid_next;
      len_reg    <= len_next;
      refill_reg <= refill_next;
      done_reg   <= done_next;
      if (capture) begin
        data_reg <= bus.buf_rdata;
      end
    end
  end

  // Holds cmd_ready low until the first cycle after reset is released
  always_ff @(posedge clk_48m) begin
    if (rst) begin
      rdy_en_reg <= 1'b0;
    end else begin
      rdy_en_reg <= 1'b1;
    end
  end

  // Next-state logic, RAM read strobe and pointer/count updates
  always_comb begin
    state_next  = state_reg;
    ptr_next    = ptr_reg;
    rem_next    = rem_reg;
    pid_next    = pid_reg;
    len_next    = len_reg;
    refill_next = 1'b0;
    done_next   = 1'b0;
    rd_en       = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (bus.cmd_valid && rdy_en_reg) begin
          pid_next   = bus.cmd_pid;
          len_next   = bus.cmd_len;
          ptr_next   = bus.cmd_addr;
          rem_next   = bus.cmd_len;
          state_next = (bus.cmd_len != 10'd0) ? S_PREFETCH : S_START;
        end
      end
      S_PREFETCH: begin
        rd_en      = 1'b1;
        state_next = S_PRE_CAP;
      end
      S_PRE_CAP: begin
        ptr_next   = ptr_reg + ADDR_W'(1);
        state_next = S_START;
      end
      S_START: begin
        state_next = (len_reg != 10'd0) ? S_XFER : S_WAIT_DONE;
      end
      S_XFER: begin
        // an early pkt_done wins over a coincident ack
        if (bus.pkt_done) begin
          state_next = S_IDLE;
          done_next  = 1'b1;
        end else if (bus.pkt_data_ack) begin
          rem_next = rem_reg - 10'd1;
          if (rem_reg > 10'd1) begin
            rd_en       = 1'b1;
            ptr_next    = ptr_reg + ADDR_W'(1);
            refill_next = 1'b1;
          end else begin
            state_next = S_WAIT_DONE;
          end
        end
      end
      S_WAIT_DONE: begin
        if (bus.pkt_done) begin
          state_next = S_IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign bus.cmd_ready = (state_reg == S_IDLE) && rdy_en_reg;
  assign bus.buf_re    = rd_en;
  assign bus.buf_addr  = ptr_reg;
  assign bus.pkt_start = (state_reg == S_START);
  assign bus.pkt_pid   = pid_reg;
  assign bus.pkt_len   = len_reg;
  assign bus.pkt_data  = data_reg;
  assign busy          = (state_reg != S_IDLE);
  assign done          = done_reg;

`ifdef USB_TX_BUF_SRC_CHECK_EN
  logic err_reg;
  logic err_evt;

  assign err_evt = (bus.pkt_data_ack && (state_reg != S_XFER)) ||
                   (bus.pkt_done && (state_reg == S_XFER) && (rem_reg != 10'd0)) ||
                   (bus.pkt_done && ((state_reg == S_PREFETCH) ||
                                     (state_reg == S_PRE_CAP)  ||
                                     (state_reg == S_START)));

  // Sticky protocol-violation flag, cleared only by reset
  always_ff @(posedge clk_48m) begin
    if (rst) begin
      err_reg <= 1'b0;
    end else if (err_evt) begin
      err_reg <= 1'b1;
    end
  end

  assign err = err_reg;
`endif

endmodule
